// File: rtl/qu_dispatch.sv
// qu_dispatch: dispatch stage after rename; allocates RS slots, tags source readiness.
// Optional stats counters enabled by defining QU_DISPATCH_STATS_EN.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   flush, stall       pipeline flush, external stall
//   uop_*              renamed uop from RN (valid/ready handshake)
//   rs_wr_*            registered RS write (one cycle after accept)
//   rs_free_en/addr    slot release from issue
//   wb_en/wb_addr      writeback broadcast clearing busy bits
//   free_cnt           number of free RS slots
//   dp_stall           uop_valid && !uop_ready
//   stat_* (opt.)      saturating accept / full-with-valid cycle counters
module qu_dispatch #(
    parameter int UOP_WIDTH      = 64,
    parameter int PHY_ADDR_WIDTH = 6,
    parameter int RS_ENTRIES     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          stall,
    input  logic                          uop_valid,
    output logic                          uop_ready,
    input  logic [UOP_WIDTH-1:0]          uop_data,
    input  logic [PHY_ADDR_WIDTH-1:0]     uop_rs1,
    input  logic [PHY_ADDR_WIDTH-1:0]     uop_rs2,
    input  logic [PHY_ADDR_WIDTH-1:0]     uop_rd,
    input  logic                          uop_has_rd,
    output logic                          rs_wr_en,
    output logic [$clog2(RS_ENTRIES)-1:0] rs_wr_addr,
    output logic [UOP_WIDTH-1:0]          rs_wr_data,
    output logic                          rs_wr_src1_rdy,
    output logic                          rs_wr_src2_rdy,
    input  logic                          rs_free_en,
    input  logic [$clog2(RS_ENTRIES)-1:0] rs_free_addr,
    input  logic                          wb_en,
    input  logic [PHY_ADDR_WIDTH-1:0]     wb_addr,
    output logic [$clog2(RS_ENTRIES):0]   free_cnt,
    output logic                          dp_stall
`ifdef QU_DISPATCH_STATS_EN
    ,
    output logic [31:0]                   stat_dispatched,
    output logic [31:0]                   stat_full_cycles
`endif
);

    localparam int IDX_W = $clog2(RS_ENTRIES);
    localparam int CNT_W = IDX_W + 1;
    localparam int NREG  = 1 << PHY_ADDR_WIDTH;

    logic [RS_ENTRIES-1:0] slot_used;
    logic [NREG-1:0]       busy;

    logic [IDX_W-1:0]      alloc_idx;
    logic                  accept;
    logic                  src1_rdy;
    logic                  src2_rdy;

    // free_cnt derived from the bitmap so the two can never disagree.
    always_comb begin
        free_cnt = CNT_W'(RS_ENTRIES);
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (slot_used[i]) free_cnt = free_cnt - CNT_W'(1);
        end
    end

    // Lowest-index free slot: scan downward so the last hit is the smallest.
    always_comb begin
        alloc_idx = '0;
        for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
            if (!slot_used[i]) alloc_idx = IDX_W'(i);
        end
    end

    assign uop_ready = !rst && !flush && !stall && (free_cnt != '0);
    assign accept    = uop_valid && uop_ready;
    assign dp_stall  = uop_valid && !uop_ready;

    // Same-cycle writeback bypass; p0 is the hardwired zero register.
    assign src1_rdy = (uop_rs1 == '0) || !busy[uop_rs1] ||
                      (wb_en && (wb_addr == uop_rs1));
    assign src2_rdy = (uop_rs2 == '0) || !busy[uop_rs2] ||
                      (wb_en && (wb_addr == uop_rs2));

    // Slot bitmap: release first, then allocation (disjoint slots anyway).
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            slot_used <= '0;
        end else begin
            logic [RS_ENTRIES-1:0] nxt;
            nxt = slot_used;
            if (rs_free_en) nxt[rs_free_addr] = 1'b0;
            if (accept) nxt[alloc_idx] = 1'b1;
            slot_used <= nxt;
        end
    end

    // Busy table: writeback clears, a new destination sets and wins on collision.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            busy <= '0;
        end else begin
            logic [NREG-1:0] nxt;
            nxt = busy;
            if (wb_en) nxt[wb_addr] = 1'b0;
            if (accept && uop_has_rd && (uop_rd != '0)) nxt[uop_rd] = 1'b1;
            busy <= nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rs_wr_en       <= 1'b0;
            rs_wr_addr     <= '0;
            rs_wr_data     <= '0;
            rs_wr_src1_rdy <= 1'b0;
            rs_wr_src2_rdy <= 1'b0;
        end else begin
            rs_wr_en <= accept;
            if (accept) begin
                rs_wr_addr     <= alloc_idx;
                rs_wr_data     <= uop_data;
                rs_wr_src1_rdy <= src1_rdy;
                rs_wr_src2_rdy <= src2_rdy;
            end
        end
    end

`ifdef QU_DISPATCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_dispatched  <= '0;
            stat_full_cycles <= '0;
        end else begin
            if (accept && (stat_dispatched != '1))
                stat_dispatched <= stat_dispatched + 32'd1;
            if (uop_valid && (free_cnt == '0) && (stat_full_cycles != '1))
                stat_full_cycles <= stat_full_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_qu_dispatch.sv
// tb_qu_dispatch: directed scoreboard bench for qu_dispatch.
// Stats checks compiled in when QU_DISPATCH_STATS_EN is defined.
module tb_qu_dispatch;

    logic        clk = 1'b0;
    logic        rst, flush, stall;
    logic        uop_valid, uop_ready;
    logic [63:0] uop_data;
    logic [5:0]  uop_rs1, uop_rs2, uop_rd;
    logic        uop_has_rd;
    logic        rs_wr_en;
    logic [2:0]  rs_wr_addr;
    logic [63:0] rs_wr_data;
    logic        rs_wr_src1_rdy, rs_wr_src2_rdy;
    logic        rs_free_en;
    logic [2:0]  rs_free_addr;
    logic        wb_en;
    logic [5:0]  wb_addr;
    logic [3:0]  free_cnt;
    logic        dp_stall;
`ifdef QU_DISPATCH_STATS_EN
    logic [31:0] stat_dispatched, stat_full_cycles;
`endif

    always #5 clk = ~clk;

    qu_dispatch dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .uop_valid(uop_valid), .uop_ready(uop_ready),
        .uop_data(uop_data), .uop_rs1(uop_rs1), .uop_rs2(uop_rs2),
        .uop_rd(uop_rd), .uop_has_rd(uop_has_rd),
        .rs_wr_en(rs_wr_en), .rs_wr_addr(rs_wr_addr),
        .rs_wr_data(rs_wr_data),
        .rs_wr_src1_rdy(rs_wr_src1_rdy), .rs_wr_src2_rdy(rs_wr_src2_rdy),
        .rs_free_en(rs_free_en), .rs_free_addr(rs_free_addr),
        .wb_en(wb_en), .wb_addr(wb_addr),
        .free_cnt(free_cnt), .dp_stall(dp_stall)
`ifdef QU_DISPATCH_STATS_EN
        , .stat_dispatched(stat_dispatched),
        .stat_full_cycles(stat_full_cycles)
`endif
    );

    typedef struct packed {
        logic [2:0]  addr;
        logic [63:0] data;
        logic        s1;
        logic        s2;
    } wr_t;

    wr_t         sbq[$];
    int          pass_cnt = 0;
    int          fail_cnt = 0;
    int          total    = 0;
    logic [7:0]  m_alloc;
    logic [63:0] m_busy;
    logic        m_pend;
    logic [31:0] m_disp, m_full;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs already driven after negedge.
    task automatic tick();
        logic exp_rdy, acc;
        int   slot;
        wr_t  e;
        #1;
        exp_rdy = !rst && !flush && !stall && (m_alloc != 8'hFF);
        chk("uop_ready", uop_ready, exp_rdy);
        chk("dp_stall", dp_stall, uop_valid && !exp_rdy);
        chk("free_cnt", free_cnt, 8 - $countones(m_alloc));
        acc  = uop_valid && exp_rdy;
        slot = 0;
        for (int i = 7; i >= 0; i--) if (!m_alloc[i]) slot = i;
        if (acc) begin
            e.addr = 3'(slot);
            e.data = uop_data;
            e.s1 = (uop_rs1 == 0) || !m_busy[uop_rs1] ||
                   (wb_en && wb_addr == uop_rs1);
            e.s2 = (uop_rs2 == 0) || !m_busy[uop_rs2] ||
                   (wb_en && wb_addr == uop_rs2);
            sbq.push_back(e);
        end
        if (rst) begin
            m_disp = 0;
            m_full = 0;
        end else begin
            if (acc && m_disp != 32'hFFFF_FFFF) m_disp++;
            if (uop_valid && m_alloc == 8'hFF && m_full != 32'hFFFF_FFFF)
                m_full++;
        end
        if (rst || flush) begin
            m_alloc = '0;
            m_busy  = '0;
            m_pend  = 1'b0;
        end else begin
            if (rs_free_en) m_alloc[rs_free_addr] = 1'b0;
            if (wb_en) m_busy[wb_addr] = 1'b0;
            if (acc) begin
                m_alloc[slot] = 1'b1;
                if (uop_has_rd && uop_rd != 0) m_busy[uop_rd] = 1'b1;
            end
            m_pend = acc;
        end
        @(posedge clk);
        #1;
        chk("rs_wr_en", rs_wr_en, m_pend);
        if (m_pend) begin
            if (sbq.size() == 0) begin
                chk("sbq_underflow", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("wr_addr", rs_wr_addr, e.addr);
                chk("wr_data", rs_wr_data, e.data);
                chk("wr_src1", rs_wr_src1_rdy, e.s1);
                chk("wr_src2", rs_wr_src2_rdy, e.s2);
            end
        end
        @(negedge clk);
        uop_valid  = 1'b0;
        rs_free_en = 1'b0;
        wb_en      = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic send(input logic [63:0] d, input logic [5:0] r1,
                        input logic [5:0] r2, input logic [5:0] rd,
                        input logic hr);
        uop_valid  = 1'b1;
        uop_data   = d;
        uop_rs1    = r1;
        uop_rs2    = r2;
        uop_rd     = rd;
        uop_has_rd = hr;
        tick();
    endtask

    initial begin
        rst = 1'b1; flush = 0; stall = 0; uop_valid = 0;
        uop_data = 0; uop_rs1 = 0; uop_rs2 = 0; uop_rd = 0;
        uop_has_rd = 0; rs_free_en = 0; rs_free_addr = 0;
        wb_en = 0; wb_addr = 0;
        m_alloc = 0; m_busy = 0; m_pend = 0; m_disp = 0; m_full = 0;
        @(posedge clk);
        @(negedge clk);

        // Reset held: not ready even with a valid uop.
        uop_valid = 1'b1;
        tick();
        chk("rst_wr_en", rs_wr_en, 0);
        chk("rst_free_cnt", free_cnt, 8);
        rst = 1'b0;

        // Three back-to-back uops.
        send(64'hA000_0001, 6'd1, 6'd2, 6'd5, 1);
        chk("b2b_addr0", rs_wr_addr, 0);
        send(64'hA000_0002, 6'd3, 6'd4, 6'd6, 1);
        chk("b2b_addr1", rs_wr_addr, 1);
        send(64'hA000_0003, 6'd5, 6'd6, 6'd7, 1);
        chk("b2b_addr2", rs_wr_addr, 2);
        chk("b2b_src1_busy5", rs_wr_src1_rdy, 0);
        chk("b2b_free_cnt", free_cnt, 5);

        // Flush with five slots allocated.
        send(64'hB0, 6'd7, 6'd0, 6'd8, 1);
        send(64'hB1, 6'd8, 6'd0, 6'd10, 1);
        uop_valid = 1'b1;
        flush = 1'b1;
        tick();
        chk("flush_wr_en", rs_wr_en, 0);
        chk("flush_free_cnt", free_cnt, 8);

        // Fill all eight, then try a ninth.
        for (int i = 0; i < 8; i++)
            send(64'hC0 + 64'(i), 6'(i), 6'(i + 1), 6'd0, 0);
        uop_valid = 1'b1;
        #1;
        chk("full_ready", uop_ready, 0);
        chk("full_dp_stall", dp_stall, 1);
        tick();
        uop_valid = 1'b1;
        rs_free_en = 1'b1;
        rs_free_addr = 3'd3;
        tick();
        send(64'hD3, 6'd0, 6'd0, 6'd0, 0);
        chk("refill_slot3", rs_wr_addr, 3);

        // Busy tracking and writeback bypass.
        flush = 1'b1;
        tick();
        send(64'hE0, 6'd1, 6'd2, 6'd9, 1);
        send(64'hE1, 6'd9, 6'd0, 6'd0, 0);
        chk("busy9_src1", rs_wr_src1_rdy, 0);
        wb_en = 1'b1;
        wb_addr = 6'd9;
        send(64'hE2, 6'd9, 6'd0, 6'd0, 0);
        chk("bypass9_src1", rs_wr_src1_rdy, 1);
        send(64'hE3, 6'd0, 6'd9, 6'd0, 0);
        chk("cleared9_src2", rs_wr_src2_rdy, 1);

        // Set wins over writeback on the same register.
        wb_en = 1'b1;
        wb_addr = 6'd12;
        send(64'hF0, 6'd0, 6'd0, 6'd12, 1);
        send(64'hF1, 6'd12, 6'd0, 6'd0, 0);
        chk("collide12_src1", rs_wr_src1_rdy, 0);
        chk("zero_src2", rs_wr_src2_rdy, 1);

        // Double free ignored; stall blocks acceptance.
        flush = 1'b1;
        tick();
        rs_free_en = 1'b1;
        rs_free_addr = 3'd5;
        tick();
        chk("dbl_free_cnt", free_cnt, 8);
        stall = 1'b1;
        uop_valid = 1'b1;
        tick();
        stall = 1'b0;

        // Reset mid-run, then 10 accepts with 4 full-valid cycles.
        send(64'h11, 6'd0, 6'd0, 6'd3, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_free_cnt", free_cnt, 8);
        for (int i = 0; i < 8; i++)
            send(64'h200 + 64'(i), 6'd3, 6'd0, 6'd0, 0);
        chk("after_rst_src1", rs_wr_src1_rdy, 1);
        for (int i = 0; i < 4; i++) begin
            uop_valid = 1'b1;
            tick();
        end
        rs_free_en = 1'b1;
        rs_free_addr = 3'd0;
        tick();
        rs_free_en = 1'b1;
        rs_free_addr = 3'd1;
        tick();
        send(64'h300, 6'd0, 6'd0, 6'd0, 0);
        send(64'h301, 6'd0, 6'd0, 6'd0, 0);
        chk("final_free_cnt", free_cnt, 0);
`ifdef QU_DISPATCH_STATS_EN
        chk("stat_dispatched", stat_dispatched, 10);
        chk("stat_full_cycles", stat_full_cycles, 4);
        chk("stat_disp_model", stat_dispatched, m_disp);
        chk("stat_full_model", stat_full_cycles, m_full);
`endif
        chk("sbq_empty", sbq.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
